// File: rtl/sar_adc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sar_adc_ctrl
// Purpose  : SAR ADC controller: sample phase, MSB-first successive
//            approximation, two's-complement result. Optional back-to-back
//            conversions when SAR_ADC_CONTINUOUS_EN is defined.
// Revision : 1.0
// ============================================================================
module sar_adc_ctrl #(
  parameter int BITWIDTH      = 6,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                comparator_in,
`ifdef SAR_ADC_CONTINUOUS_EN
  input  logic                continuous,
`endif
  output logic [BITWIDTH-1:0] dac_data,
  output logic                dac_enable,
  output logic                sample,
  output logic                busy,
  output logic [BITWIDTH-1:0] result,
  output logic                result_valid
);

  localparam int c_cnt_max = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;
  localparam int c_idx_w   = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;

  localparam logic [c_cnt_w-1:0]  c_cnt_one     = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0]  c_sample_last = c_cnt_w'(SAMPLE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0]  c_settle_last = c_cnt_w'(SETTLE_CYCLES - 1);
  localparam logic [c_idx_w-1:0]  c_idx_one     = c_idx_w'(1);
  localparam logic [c_idx_w-1:0]  c_msb_idx     = c_idx_w'(BITWIDTH - 1);
  // Offset-binary mid-scale; XOR with it converts offset binary <-> two's complement.
  localparam logic [BITWIDTH-1:0] c_msb_trial   = {1'b1, {(BITWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAMPLE  = 2'd1,
    ST_CONVERT = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t              r_state;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [c_idx_w-1:0]  r_bit_idx;
  logic [BITWIDTH-1:0] r_sar;
  logic [BITWIDTH-1:0] w_decided;
  logic [BITWIDTH-1:0] w_next_trial;
  logic                w_continuous;

`ifdef SAR_ADC_CONTINUOUS_EN
  assign w_continuous = continuous;
`else
  assign w_continuous = 1'b0;
`endif

  // Current trial with bit k resolved, and the following trial with bit k-1 set.
  always_comb begin
    w_decided            = r_sar;
    w_decided[r_bit_idx] = comparator_in;
    w_next_trial         = w_decided;
    if (r_bit_idx != '0) begin
      w_next_trial[r_bit_idx - c_idx_one] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_bit_idx    <= '0;
      r_sar        <= '0;
      dac_data     <= '0;
      dac_enable   <= 1'b0;
      sample       <= 1'b0;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state    <= ST_SAMPLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_sar      <= '0;
            dac_data   <= '0;
            dac_enable <= 1'b1;
            sample     <= 1'b1;
            busy       <= 1'b1;
          end
        end

        ST_SAMPLE: begin
          if (r_cnt == c_sample_last) begin
            r_state   <= ST_CONVERT;
            r_cnt     <= '0;
            r_bit_idx <= c_msb_idx;
            r_sar     <= c_msb_trial;
            dac_data  <= '0;
            sample    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end

        ST_CONVERT: begin
          // The comparator is only looked at on the edge closing each bit phase.
          if (r_cnt == c_settle_last) begin
            r_cnt <= '0;
            if (r_bit_idx == '0) begin
              r_state      <= ST_DONE;
              r_sar        <= w_decided;
              result       <= w_decided ^ c_msb_trial;
              result_valid <= 1'b1;
              dac_data     <= '0;
              dac_enable   <= 1'b0;
            end else begin
              r_bit_idx <= r_bit_idx - c_idx_one;
              r_sar     <= w_next_trial;
              dac_data  <= w_next_trial ^ c_msb_trial;
            end
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end

        ST_DONE: begin
          r_cnt     <= '0;
          r_bit_idx <= '0;
          r_sar     <= '0;
          dac_data  <= '0;
          if (w_continuous) begin
            r_state    <= ST_SAMPLE;
            dac_enable <= 1'b1;
            sample     <= 1'b1;
            busy       <= 1'b1;
          end else begin
            r_state    <= ST_IDLE;
            dac_enable <= 1'b0;
            sample     <= 1'b0;
            busy       <= 1'b0;
          end
        end

        default: begin
          r_state    <= ST_IDLE;
          r_cnt      <= '0;
          r_bit_idx  <= '0;
          r_sar      <= '0;
          dac_data   <= '0;
          dac_enable <= 1'b0;
          sample     <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sar_adc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sar_adc_ctrl
// Purpose  : Scoreboard bench for sar_adc_ctrl with an ideal comparator model.
// Revision : 1.0
// ============================================================================
module tb_sar_adc_ctrl;

  localparam int LAT = 17;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       comparator_in;
`ifdef SAR_ADC_CONTINUOUS_EN
  logic       continuous;
`endif
  logic [5:0] dac_data;
  logic       dac_enable;
  logic       sample;
  logic       busy;
  logic [5:0] result;
  logic       result_valid;

  int vin      = 0;
  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [5:0] res;
    int         at;
  } exp_t;

  exp_t sb[$];

  logic [5:0] trace5 [12] = '{6'h00, 6'h00, 6'h10, 6'h10, 6'h08, 6'h08,
                              6'h04, 6'h04, 6'h06, 6'h06, 6'h05, 6'h05};

  sar_adc_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .comparator_in(comparator_in),
`ifdef SAR_ADC_CONTINUOUS_EN
    .continuous   (continuous),
`endif
    .dac_data     (dac_data),
    .dac_enable   (dac_enable),
    .sample       (sample),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Ideal comparator: analog input vs. two's-complement DAC code.
  assign comparator_in = (vin >= int'($signed(dac_data)));

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && result_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result_valid actual=0x%0h required=no_pulse (cycle %0d)", result, cyc);
      end else begin
        e = sb.pop_front();
        check("result_value", result, e.res);
        check("result_latency", cyc, e.at);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic launch(input int v, input logic [5:0] r);
    vin   = v;
    start = 1'b1;
    sb.push_back('{res: r, at: cyc + LAT});
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || sb.size() != 0) && n < 80) begin
      tick(1);
      n++;
    end
    if (busy || sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=busy%0b_pending%0d required=idle", name, busy, sb.size());
      sb.delete();
    end
    tick(1);
  endtask

  initial begin
    int s;
    rst   = 1'b1;
    start = 1'b0;
`ifdef SAR_ADC_CONTINUOUS_EN
    continuous = 1'b0;
`endif
    tick(3);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_dac_enable", dac_enable, 0);
    check("rst_sample", sample, 0);
    check("rst_dac_data", dac_data, 0);
    rst = 1'b0;
    tick(2);

    // vin=+5: phase-by-phase output trace
    s     = cyc;
    vin   = 5;
    start = 1'b1;
    sb.push_back('{res: 6'h05, at: s + LAT});
    for (int k = 1; k <= 17; k++) begin
      tick(1);
      start = 1'b0;
      if (k <= 4) begin
        check("sample_phase_sample", sample, 1);
        check("sample_phase_dac", dac_data, 0);
      end else if (k <= 16) begin
        check("convert_dac_trial", dac_data, trace5[k-5]);
        check("convert_sample_low", sample, 0);
      end else begin
        check("done_dac_enable", dac_enable, 0);
        check("done_busy", busy, 1);
      end
    end
    wait_idle("vin5");

    launch(17, 6'h11);
    wait_idle("vin17");
    launch(-32, 6'h20);
    wait_idle("vin_m32");
    launch(0, 6'h00);
    check("vin0_first_trial_dac", dac_data, 0);
    wait_idle("vin0");
    launch(31, 6'h1F);
    wait_idle("vin31");
    tick(5);
    check("result_hold", result, 6'h1F);
    check("idle_busy", busy, 0);

    // start re-pulsed mid-conversion must be ignored
    s = cyc;
    launch(17, 6'h11);
    tick(2);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(6);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(7);
    check("repulse_cycle", cyc, s + 18);
    check("repulse_busy_after", busy, 0);
    tick(20);
    check("repulse_pending", sb.size(), 0);

    // reset at cycle 8 aborts without a result
    s     = cyc;
    vin   = 17;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(7);
    rst = 1'b1;
    tick(1);
    check("abort_busy", busy, 0);
    check("abort_result", result, 0);
    check("abort_result_valid", result_valid, 0);
    check("abort_dac_enable", dac_enable, 0);
    rst = 1'b0;
    tick(25);

    // reset wins over start on the same edge
    rst   = 1'b1;
    start = 1'b1;
    tick(1);
    rst   = 1'b0;
    start = 1'b0;
    check("rst_priority_busy", busy, 0);
    tick(1);
    check("rst_priority_busy_next", busy, 0);

`ifdef SAR_ADC_CONTINUOUS_EN
    s          = cyc;
    continuous = 1'b1;
    vin        = 9;
    start      = 1'b1;
    sb.push_back('{res: 6'h09, at: s + LAT});
    sb.push_back('{res: 6'h09, at: s + 2*LAT});
    sb.push_back('{res: 6'h09, at: s + 3*LAT});
    tick(1);
    start = 1'b0;
    tick(17);
    check("cont_sample_after_pulse1", sample, 1);
    tick(17);
    check("cont_sample_after_pulse2", sample, 1);
    continuous = 1'b0;
    wait_idle("continuous");
    check("cont_busy_end", busy, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
